// File: rtl/hs_slave_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : hs_slave_mux_if
//  Description : Bundle of the per-channel req/ack/data lines and the capture
//                FIFO drain port of hs_slave_mux. The slave modport is the
//                mux side; the master modport is the channel masters plus the
//                downstream consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hs_slave_mux_if #(
    parameter int DATA_W     = 8,
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 8
);
    localparam int c_CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [N_CH-1:0]        req;
    logic [N_CH*DATA_W-1:0] data_in;
    logic [N_CH-1:0]        ack;
    logic [N_CH*DATA_W-1:0] last_word;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [c_CH_W-1:0]      out_ch;
    logic                   out_ready;
    logic [c_CNT_W-1:0]     fifo_count;
    logic                   timeout_err;
    logic [c_CH_W-1:0]      err_ch;

    modport slave (
        input  req, data_in, out_ready,
        output ack, last_word, out_valid, out_data, out_ch,
               fifo_count, timeout_err, err_ch
    );

    modport master (
        output req, data_in, out_ready,
        input  ack, last_word, out_valid, out_data, out_ch,
               fifo_count, timeout_err, err_ch
    );
endinterface
`default_nettype wire

// File: rtl/hs_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module      : hs_slave_mux
//  Description : N_CH 4-phase req/ack slave channels served by one shared
//                handshake engine with round-robin arbitration. Each accepted
//                word is pushed, tagged with its channel, into a capture FIFO
//                drained with valid/ready. Includes ack hold time, FIFO
//                backpressure, per-channel last word and a req-drop timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_slave_mux #(
    parameter int DATA_W     = 8,
    parameter int N_CH       = 4,
    parameter int ACK_HOLD   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 16
) (
    input wire            clk,
    input wire            rst,
    hs_slave_mux_if.slave bus
);
    localparam int c_CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_HOLD_W = $clog2(ACK_HOLD + 1);
    localparam int c_TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int c_ENT_W  = c_CH_W + DATA_W;
    localparam int c_IDX_W  = c_CH_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [c_CH_W-1:0]      gch_q;
    logic [c_CH_W-1:0]      rr_q;
    logic [c_CH_W-1:0]      rr_d;
    logic [c_CH_W-1:0]      err_ch_q;
    logic [N_CH-1:0]        stale_q;
    logic [N_CH-1:0]        ack_q;
    logic [c_HOLD_W-1:0]    hold_q;
    logic [c_TO_W-1:0]      to_q;
    logic                   timeout_err_q;
    logic [N_CH*DATA_W-1:0] last_word_q;

    logic [c_ENT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     wr_ptr_q;
    logic [c_PTR_W-1:0]     rd_ptr_q;
    logic [c_CNT_W-1:0]     count_q;
    logic [c_CNT_W-1:0]     count_d;

    logic [N_CH-1:0]        w_elig;
    logic                   w_any;
    logic [c_CH_W-1:0]      w_gnt;
    logic [c_IDX_W-1:0]     w_idx;
    logic [DATA_W-1:0]      w_cap_data;
    logic [N_CH-1:0]        w_gnt_oh;
    logic [N_CH-1:0]        w_gch_oh;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;

    // A channel that timed out stays ineligible until its master drops req.
    assign w_elig     = bus.req & ~stale_q;
    assign w_full     = (count_q == c_CNT_W'(FIFO_DEPTH));
    assign w_push     = (state_q == ST_IDLE) && w_any && !w_full;
    assign w_pop      = (count_q != '0) && bus.out_ready;
    assign w_cap_data = bus.data_in[int'(w_gnt)*DATA_W +: DATA_W];
    assign w_gnt_oh   = {{(N_CH-1){1'b0}}, 1'b1} << w_gnt;
    assign w_gch_oh   = {{(N_CH-1){1'b0}}, 1'b1} << gch_q;
    assign rr_d       = (w_gnt == c_CH_W'(N_CH - 1)) ? '0 : w_gnt + c_CH_W'(1);

    // Round-robin search: first eligible channel at or above rr, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = {1'b0, rr_q} + c_IDX_W'(k);
            if (w_idx >= c_IDX_W'(N_CH)) begin
                w_idx = w_idx - c_IDX_W'(N_CH);
            end
            if (!w_any && w_elig[w_idx[c_CH_W-1:0]]) begin
                w_any = 1'b1;
                w_gnt = w_idx[c_CH_W-1:0];
            end
        end
    end

    // Handshake engine: capture in IDLE, hold ack, then wait for req release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gch_q         <= '0;
            rr_q          <= '0;
            err_ch_q      <= '0;
            stale_q       <= '0;
            ack_q         <= '0;
            hold_q        <= '0;
            to_q          <= '0;
            timeout_err_q <= 1'b0;
            last_word_q   <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            stale_q       <= stale_q & bus.req;
            case (state_q)
                ST_IDLE: begin
                    if (w_push) begin
                        gch_q   <= w_gnt;
                        rr_q    <= rr_d;
                        hold_q  <= c_HOLD_W'(ACK_HOLD);
                        ack_q   <= w_gnt_oh;
                        state_q <= ST_ACK;
                        last_word_q[int'(w_gnt)*DATA_W +: DATA_W] <= w_cap_data;
                    end
                end
                ST_ACK: begin
                    if (hold_q == c_HOLD_W'(1)) begin
                        ack_q   <= '0;
                        to_q    <= '0;
                        state_q <= ST_DROP;
                    end else begin
                        hold_q <= hold_q - c_HOLD_W'(1);
                    end
                end
                ST_DROP: begin
                    if (!bus.req[gch_q]) begin
                        state_q <= ST_IDLE;
                    end else if (TIMEOUT > 0) begin
                        if (to_q == c_TO_W'(TIMEOUT - 1)) begin
                            timeout_err_q <= 1'b1;
                            err_ch_q      <= gch_q;
                            stale_q       <= (stale_q & bus.req) | w_gch_oh;
                            state_q       <= ST_IDLE;
                        end else begin
                            to_q <= to_q + c_TO_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= '0;
                end
            endcase
        end
    end

    // Occupancy after this edge's push and/or pop.
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Capture storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {w_gnt, w_cap_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.last_word   = last_word_q;
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_data    = mem_q[rd_ptr_q][DATA_W-1:0];
    assign bus.out_ch      = mem_q[rd_ptr_q][c_ENT_W-1:DATA_W];
    assign bus.fifo_count  = count_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_ch      = err_ch_q;

endmodule
`default_nettype wire
